// File: rtl/tagger_pkg.sv
// Shared constants and helpers for the photon-tag RAM FIFO controller.
package tagger_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned ADDR_W     = 9;
  localparam int unsigned DEPTH      = 1 << ADDR_W;
  localparam int unsigned RD_LAT     = 2;
  localparam int unsigned CREDIT_LIM = RD_LAT + 1;

  // Skid holds every word that can be in flight when downstream stalls.
  localparam int unsigned SKID_DEPTH = CREDIT_LIM;
  localparam int unsigned SKID_CNT_W = $clog2(SKID_DEPTH + 1);
  localparam int unsigned CRED_W     = SKID_CNT_W + 1;
  localparam int unsigned LEVEL_W    = ADDR_W + 1;

  typedef logic [DATA_W-1:0] word_t;

  // Number of reads currently travelling through the RAM read pipeline.
  function automatic logic [CRED_W-1:0] count_inflight(input logic [RD_LAT-1:0] pipe);
    logic [CRED_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      n = n + CRED_W'(pipe[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/rd_skid_fifo.sv
// Small shifting register FIFO catching RAM read data; head entry is a register.
module rd_skid_fifo
  import tagger_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_W-1:0]     push_data_i,
  input  logic                  pop_i,
  output logic [DATA_W-1:0]     head_o,
  output logic                  valid_o,
  output logic [SKID_CNT_W-1:0] count_o
);

  word_t                 data_q [SKID_DEPTH];
  word_t                 data_d [SKID_DEPTH];
  logic [SKID_CNT_W-1:0] cnt_q, cnt_d, wr_idx;
  logic                  valid_q, valid_d;

  // Shift on pop, write behind the last surviving entry on push; flush empties.
  always_comb begin
    data_d  = data_q;
    cnt_d   = cnt_q;
    wr_idx  = cnt_q - SKID_CNT_W'(pop_i);
    valid_d = 1'b0;
    if (pop_i) begin
      for (int unsigned i = 0; i < SKID_DEPTH - 1; i++) begin
        data_d[i] = data_q[i+1];
      end
    end
    if (push_i) begin
      for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
        if (wr_idx == SKID_CNT_W'(i)) begin
          data_d[i] = push_data_i;
        end
      end
    end
    cnt_d = cnt_q + SKID_CNT_W'(push_i) - SKID_CNT_W'(pop_i);
    if (flush_i) begin
      cnt_d = '0;
    end
    valid_d = (cnt_d != '0);
  end

  // Storage, occupancy and registered head-valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
        data_q[i] <= '0;
      end
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign head_o  = data_q[0];
  assign valid_o = valid_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FWFT FIFO controller sequencing the dual-port photon-tag RAM.
module ram_fifo_ctrl
  import tagger_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               flush,
  output logic [LEVEL_W-1:0] level,
  output logic               empty,
  output logic               full,
  output logic [ADDR_W-1:0]  ram_wr_adr,
  output logic [DATA_W-1:0]  ram_data_in,
  output logic               ram_wr_en,
  output logic [ADDR_W-1:0]  ram_rd_adr,
  output logic               ram_rd_en,
  input  logic [DATA_W-1:0]  ram_data_out
);

  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0]    ram_cnt_q, ram_cnt_d;
  logic [LEVEL_W-1:0]    level_q, level_d;
  logic [RD_LAT-1:0]     pipe_q, pipe_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  accept, pop, issue, push;
  logic [CRED_W-1:0]     credit_used;
  logic [SKID_CNT_W-1:0] skid_cnt;

  // Handshakes and read-issue decision; credits keep the skid from overflowing.
  always_comb begin
    in_ready    = (ram_cnt_q != LEVEL_W'(DEPTH)) & ~flush;
    accept      = in_valid & in_ready;
    pop         = out_valid & out_ready;
    push        = pipe_q[RD_LAT-1];
    credit_used = count_inflight(pipe_q) + CRED_W'(skid_cnt) - CRED_W'(pop);
    issue       = (ram_cnt_q != '0) & (credit_used < CRED_W'(CREDIT_LIM)) & ~flush;
  end

  // Next-state for pointers, counts and the read-valid pipe; flush clears all.
  always_comb begin
    wr_ptr_d  = wr_ptr_q + ADDR_W'(accept);
    rd_ptr_d  = rd_ptr_q + ADDR_W'(issue);
    ram_cnt_d = ram_cnt_q + LEVEL_W'(accept) - LEVEL_W'(issue);
    level_d   = level_q + LEVEL_W'(accept) - LEVEL_W'(pop);
    pipe_d    = {pipe_q[RD_LAT-2:0], issue};
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      ram_cnt_d = '0;
      level_d   = '0;
      pipe_d    = '0;
    end
    empty_d = (level_d == '0);
    full_d  = (ram_cnt_d == LEVEL_W'(DEPTH));
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      level_q   <= '0;
      pipe_q    <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      level_q   <= level_d;
      pipe_q    <= pipe_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
    end
  end

  rd_skid_fifo u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .push_i      (push),
    .push_data_i (ram_data_out),
    .pop_i       (pop),
    .head_o      (out_data),
    .valid_o     (out_valid),
    .count_o     (skid_cnt)
  );

  // RAM write port passes straight through; read port enable is the pipeline clock enable.
  assign ram_wr_en   = accept & rst_n;
  assign ram_wr_adr  = wr_ptr_q;
  assign ram_data_in = in_data;
  assign ram_rd_adr  = rd_ptr_q;
  assign ram_rd_en   = rst_n;

  assign level = level_q;
  assign empty = empty_q;
  assign full  = full_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Randomised bench for ram_fifo_ctrl against a queue model, with a behavioural 2-cycle RAM.
module tb_ram_fifo_ctrl;
  import tagger_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [DATA_W-1:0]  in_data = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [DATA_W-1:0]  out_data;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic               flush = 1'b0;
  logic [LEVEL_W-1:0] level;
  logic               empty;
  logic               full;
  logic [ADDR_W-1:0]  ram_wr_adr;
  logic [DATA_W-1:0]  ram_data_in;
  logic               ram_wr_en;
  logic [ADDR_W-1:0]  ram_rd_adr;
  logic               ram_rd_en;
  logic [DATA_W-1:0]  ram_data_out;

  always #5 clk = ~clk;

  ram_fifo_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .flush        (flush),
    .level        (level),
    .empty        (empty),
    .full         (full),
    .ram_wr_adr   (ram_wr_adr),
    .ram_data_in  (ram_data_in),
    .ram_wr_en    (ram_wr_en),
    .ram_rd_adr   (ram_rd_adr),
    .ram_rd_en    (ram_rd_en),
    .ram_data_out (ram_data_out)
  );

  // Dual-port RAM: address register then output register, both enabled by rd_en.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] ra_q = '0;
  logic [DATA_W-1:0] rdo_q = '0;
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_adr] <= ram_data_in;
    if (ram_rd_en) begin
      ra_q  <= ram_rd_adr;
      rdo_q <= mem[ra_q];
    end
  end
  assign ram_data_out = rdo_q;

  int tests = 0;
  int fails = 0;
  logic [DATA_W-1:0] q [$];
  int cyc = 0;
  int pops = 0;
  int first_pop_cyc = 0;
  int last_pop_cyc = 0;
  logic s_ready, s_valid;
  logic [DATA_W-1:0] s_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive, sample handshakes at negedge, update model, check level after edge.
  task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic fl);
    logic acc, pp;
    logic [DATA_W-1:0] e;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = fl;
    @(negedge clk);
    s_ready = in_ready;
    s_valid = out_valid;
    s_data  = out_data;
    acc = v & in_ready;
    pp  = out_valid & r;
    if (fl) check("flush_blocks_write", 32'(in_ready), 32'(0));
    if (pp) begin
      check("pop_has_word", 32'(q.size() != 0), 32'(1));
      if (q.size() != 0) begin
        e = q.pop_front();
        check("out_data", 32'(out_data), 32'(e));
        if (pops == 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        pops++;
      end
    end
    if (fl) q.delete();
    else if (acc) q.push_back(d);
    @(posedge clk);
    #1;
    cyc++;
    in_valid = 1'b0;
    flush    = 1'b0;
    check("level", 32'(level), 32'(q.size()));
    check("empty", 32'(empty), 32'(q.size() == 0));
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (q.size() == 0) break;
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    check("drain_done", 32'(q.size()), 32'(0));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int sent;
    int start;
    logic v, r;

    // Reset values while held in reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_level", 32'(level), 32'(0));
    check("rst_empty", 32'(empty), 32'(1));
    check("rst_full", 32'(full), 32'(0));
    check("rst_wr_en", 32'(ram_wr_en), 32'(0));
    check("rst_rd_en", 32'(ram_rd_en), 32'(0));
    check("rst_wr_adr", 32'(ram_wr_adr), 32'(0));
    check("rst_rd_adr", 32'(ram_rd_adr), 32'(0));
    check("rst_data_in", 32'(ram_data_in), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'(1));
    check("post_rst_rd_en", 32'(ram_rd_en), 32'(1));

    // Single word fall-through latency
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      cycle(1'b0, '0, 1'b0, 1'b0);
      check("sw_out_valid", 32'(s_valid), 32'(k == 4));
    end
    check("sw_out_data", 32'(s_data), 32'(8'hA5));
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("sw_popped", 32'(pops), 32'(1));

    // Fill to capacity with downstream stalled, then drain in order
    n = 0;
    for (int i = 0; i < 600; i++) begin
      cycle(1'b1, 8'(n), 1'b0, 1'b0);
      if (!s_ready) break;
      n++;
    end
    check("fill_count", 32'(n), 32'(DEPTH + CREDIT_LIM));
    check("fill_full", 32'(full), 32'(1));
    check("fill_level", 32'(level), 32'(DEPTH + CREDIT_LIM));
    check("fill_in_ready", 32'(in_ready), 32'(0));
    drain(700);
    check("drain_full", 32'(full), 32'(0));

    // Streaming at full rate across several pointer wraps
    start = cyc;
    pops = 0;
    sent = 0;
    for (int i = 0; i < 2200; i++) begin
      if (pops >= 2000) break;
      v = (sent < 2000);
      cycle(v, 8'(sent * 7 + 3), 1'b1, 1'b0);
      if (v && s_ready) sent++;
    end
    check("stream_pops", 32'(pops), 32'(2000));
    check("stream_first_latency", 32'(first_pop_cyc - start), 32'(4));
    check("stream_no_bubbles", 32'(last_pop_cyc - first_pop_cyc), 32'(1999));

    // Random backpressure on both sides
    pops = 0;
    sent = 0;
    for (int i = 0; i < 40000; i++) begin
      if (pops >= 5000) break;
      v = (sent < 5000) && ($urandom_range(1, 0) == 1);
      r = ($urandom_range(1, 0) == 1);
      cycle(v, 8'($urandom), r, 1'b0);
      if (v && s_ready) sent++;
    end
    check("bp_pops", 32'(pops), 32'(5000));
    drain(50);

    // Flush with a write attempt and two reads in flight
    cycle(1'b1, 8'h10, 1'b0, 1'b0);
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 8'h12, 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b1);
    check("flush_out_valid", 32'(out_valid), 32'(0));
    check("flush_level", 32'(level), 32'(0));
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    pops = 0;
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    drain(20);
    check("flush_recover_pops", 32'(pops), 32'(1));

    // Asynchronous reset mid-stream with reads in flight
    cycle(1'b1, 8'h20, 1'b0, 1'b0);
    cycle(1'b1, 8'h21, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    in_valid  = 1'b1;
    in_data   = 8'hEE;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    check("arst_level", 32'(level), 32'(0));
    check("arst_out_valid", 32'(out_valid), 32'(0));
    check("arst_empty", 32'(empty), 32'(1));
    check("arst_wr_en", 32'(ram_wr_en), 32'(0));
    in_valid = 1'b0;
    in_data  = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    pops = 0;
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    drain(20);
    check("arst_recover_pops", 32'(pops), 32'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
